// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states,
// ALU operation encodings and the legal-opcode decoder.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter with timeout detection. The count is cleared by
// srst (pulsed by the controller on entry to a handshake state) and advances
// on every cycle where a request is pending without ready. timeout is raised
// combinationally when the limit is reached and ready is still low, so a
// ready arriving in that same cycle takes priority.
module ctrl_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] cnt_r;
    logic          at_limit_s;

    assign at_limit_s = (cnt_r == CW'(WAIT_LIMIT));
    assign timeout    = req && !ready && at_limit_s;

    // Wait-cycle counter: clear on handshake entry, saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (req && !ready && !at_limit_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/exec/mem/writeback sequencing
// with memory handshakes, wait-state timeout and sticky halt.
// Optional feature macro: MULTICYCLE_CTRL_TRAP_ILLEGAL_EN -- when defined, an
// illegal opcode halts the core with illegal=1; otherwise it retires as a NOP.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic [31:0] ir,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [31:0] ir_r;
    logic        bus_err_r;
    logic        set_bus_err_s;
    logic [6:0]  opcode_s;
    logic        timer_clr_s;
    logic        timer_req_s;
    logic        timer_ready_s;
    logic        timeout_s;
`ifdef MULTICYCLE_CTRL_TRAP_ILLEGAL_EN
    logic        illegal_r;
    logic        set_illegal_s;
`endif

    assign opcode_s = ir_r[6:0];
    assign ir       = ir_r;
    assign bus_err  = bus_err_r;

    // Only one handshake is ever open, so the timer watches whichever is.
    assign timer_req_s   = imem_req | dmem_req;
    assign timer_ready_s = imem_req ? imem_ready : dmem_ready;
    assign timer_clr_s   = (state_nxt_s != state_r) &&
                           ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_MEM));

    ctrl_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .srst    (timer_clr_s),
        .req     (timer_req_s),
        .ready   (timer_ready_s),
        .timeout (timeout_s)
    );

    // Next-state and control decode from the current state and latched ir.
    always_comb begin
        state_nxt_s   = state_r;
        set_bus_err_s = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_ILLEGAL_EN
        set_illegal_s = 1'b0;
`endif
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 1'b0;
        alu_src_imm   = 1'b0;
        alu_op        = ALU_ADD;
        reg_we        = 1'b0;
        mem_to_reg    = 1'b0;
        halted        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nxt_s = ST_DECODE;
                end else if (timeout_s) begin
                    set_bus_err_s = 1'b1;
                    state_nxt_s   = ST_HALT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(opcode_s)) begin
                    state_nxt_s = ST_EXEC;
                end else begin
`ifdef MULTICYCLE_CTRL_TRAP_ILLEGAL_EN
                    set_illegal_s = 1'b1;
                    state_nxt_s   = ST_HALT;
`else
                    pc_we       = 1'b1;
                    state_nxt_s = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_R_TYPE: begin
                        alu_op      = ALU_FUNCT;
                        state_nxt_s = ST_WB;
                    end
                    OP_I_TYPE: begin
                        alu_op      = ALU_FUNCT;
                        alu_src_imm = 1'b1;
                        state_nxt_s = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                        state_nxt_s = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op      = ALU_CMP;
                        pc_we       = 1'b1;
                        pc_src      = branch_taken;
                        state_nxt_s = ST_FETCH;
                    end
                    default: begin
                        // Unreachable: DECODE filters opcodes. Retire safely.
                        pc_we       = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode_s == OP_STORE);
                if (dmem_ready) begin
                    if (opcode_s == OP_STORE) begin
                        pc_we       = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_WB;
                    end
                end else if (timeout_s) begin
                    set_bus_err_s = 1'b1;
                    state_nxt_s   = ST_HALT;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                mem_to_reg  = (opcode_s == OP_LOAD);
                state_nxt_s = ST_FETCH;
            end
            ST_HALT: begin
                halted      = 1'b1;
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction register: captured on the accepted fetch handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= NOP_INSTR;
        end else if ((state_r == ST_FETCH) && imem_ready) begin
            ir_r <= imem_rdata;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Sticky bus-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= bus_err_r | set_bus_err_s;
        end
    end

`ifdef MULTICYCLE_CTRL_TRAP_ILLEGAL_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | set_illegal_s;
        end
    end
    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction stream with
// random wait states, checked per instruction against a transaction-level
// model (latency, pulse counts, handshake lengths, ALU controls).
module tb_multicycle_ctrl;

    localparam int unsigned WAIT_LIMIT = 15;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    // Instruction classes used by the reference model.
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic [31:0] ir;
    logic        branch_taken;
    logic        pc_we;
    logic        pc_src;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        reg_we;
    logic        mem_to_reg;
    logic        halted;
    logic        bus_err;
    logic        illegal;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference behaviour per instruction class, indexed by K_*.
    int          lat_tab [6] = '{4, 4, 5, 4, 3, 2};
    int          regw_tab[6] = '{1, 1, 1, 0, 0, 0};
    logic [1:0]  alu_tab [6] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    logic        imm_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [6:0]  op_tab  [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

    multicycle_ctrl #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .ir           (ir),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_src_imm  (alu_src_imm),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .mem_to_reg   (mem_to_reg),
        .halted       (halted),
        .bus_err      (bus_err),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] all_outs();
        return {imem_req, dmem_req, dmem_we, pc_we, pc_src, alu_src_imm, alu_op,
                reg_we, mem_to_reg, halted, bus_err, illegal, 2'b00};
    endfunction

    function automatic logic opcode_is_legal(input logic [6:0] op);
        for (int i = 0; i < 5; i++) if (op == op_tab[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] make_instr(input int kind);
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        if (kind == K_ILL) begin
            op = r[6:0];
            while (opcode_is_legal(op)) op = op + 7'd1;
        end else begin
            op = op_tab[kind];
        end
        return {r[31:7], op};
    endfunction

    // Reset pulse, leaves the bench at negedge+1 with the DUT in FETCH.
    task automatic do_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_eq("restart_fetch", 32'(imem_req), 32'd1);
    endtask

    // Run one instruction from FETCH to the next FETCH; entered and left at
    // negedge+1 with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] instr, input int kind, input int fw,
                             input int dw, input logic bt, input string name);
        int n = 0, pcw = 0, rgw = 0, dreq = 0, dwe = 0, dwait = 0;
        int src_bad = 0, mtr = 0, mtr_bad = 0, we_bad = 0, hold_bad = 0;
        logic [1:0] alu_or = 2'b00;
        logic imm_or = 1'b0;
        int exp_n, exp_d;
        logic exp_src;
        for (int i = 0; i < fw; i++) begin
            imem_ready = 1'b0;
            @(negedge clk); #1;
            if (imem_req !== 1'b1) hold_bad++;
        end
        imem_ready = 1'b1; imem_rdata = instr; branch_taken = bt;
        @(negedge clk);
        imem_ready = 1'b0; imem_rdata = $urandom();
        exp_src = (kind == K_BR) ? bt : 1'b0;
        while (n < 60) begin
            if (dmem_req) begin
                dmem_ready = (dwait == dw);
                dwait++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
            end
            imem_ready = 1'($urandom_range(0, 1));
            #1;
            if (imem_req) break;
            n++;
            if (pc_we) begin pcw++; if (pc_src !== exp_src) src_bad++; end
            if (reg_we) begin rgw++; mtr = int'(mem_to_reg); end
            if (mem_to_reg && !reg_we) mtr_bad++;
            if (dmem_req) begin dreq++; dwe += int'(dmem_we); end
            if (dmem_we && !dmem_req) we_bad++;
            alu_or = alu_or | alu_op;
            imm_or = imm_or | alu_src_imm;
            @(negedge clk);
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_d = (kind == K_LD || kind == K_ST) ? dw + 1 : 0;
        exp_n = lat_tab[kind] - 1 + ((exp_d > 0) ? dw : 0);
        check_eq({name, "_fetch_hold"}, 32'(hold_bad), 32'd0);
        check_eq({name, "_latency"},    32'(n), 32'(exp_n));
        check_eq({name, "_pc_we"},      32'(pcw), 32'd1);
        check_eq({name, "_pc_src"},     32'(src_bad), 32'd0);
        check_eq({name, "_reg_we"},     32'(rgw), 32'(regw_tab[kind]));
        check_eq({name, "_mem_to_reg"}, 32'(mtr), (kind == K_LD) ? 32'd1 : 32'd0);
        check_eq({name, "_mtr_stray"},  32'(mtr_bad + we_bad), 32'd0);
        check_eq({name, "_dmem_req"},   32'(dreq), 32'(exp_d));
        check_eq({name, "_dmem_we"},    32'(dwe), (kind == K_ST) ? 32'(exp_d) : 32'd0);
        check_eq({name, "_alu_op"},     32'(alu_or), 32'(alu_tab[kind]));
        check_eq({name, "_alu_imm"},    32'(imm_or), 32'(imm_tab[kind]));
        check_eq({name, "_no_err"},     32'({halted, bus_err, illegal}), 32'd0);
    endtask

    initial begin
        int kind, fw, dw, k;
        int max_kind;
        logic bt;
        logic [31:0] ins;

        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
        dmem_ready = 1'b0; branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_ir",   ir, NOP_INSTR);
        check_eq("reset_outs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("idle_outs", 32'(all_outs()), 32'd0);
        @(negedge clk); #1;
        check_eq("first_fetch", 32'(imem_req), 32'd1);

        // Directed cases from the requirements.
        run_instr(32'h00500093, K_I,  0, 0, 1'b0, "addi");
        check_eq("addi_ir", ir, 32'h00500093);
        run_instr(32'h00003083, K_LD, 0, 3, 1'b0, "load_w3");
        run_instr(32'h00000463, K_BR, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h00000463, K_BR, 2, 0, 1'b0, "beq_not");
        // Ready arriving exactly when the counter hits the limit wins.
        run_instr(32'h002081b3, K_R,  WAIT_LIMIT, 0, 1'b0, "fetch_limit");
        run_instr(32'h0020a023, K_ST, 0, WAIT_LIMIT, 1'b0, "store_limit");

`ifdef MULTICYCLE_CTRL_TRAP_ILLEGAL_EN
        max_kind = K_BR;
`else
        max_kind = K_ILL;
        run_instr(32'h0000007F, K_ILL, 0, 0, 1'b0, "illegal_nop");
`endif

        // Randomized instruction stream.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, max_kind);
            fw   = ($urandom_range(0, 7) == 0) ? WAIT_LIMIT : $urandom_range(0, 4);
            dw   = ($urandom_range(0, 7) == 0) ? WAIT_LIMIT : $urandom_range(0, 4);
            bt   = 1'($urandom_range(0, 1));
            ins  = make_instr(kind);
            run_instr(ins, kind, fw, dw, bt, "rand");
        end

        // Asynchronous reset in the middle of a data handshake.
        imem_ready = 1'b1; imem_rdata = 32'h00003083;
        @(negedge clk);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        k = 0;
        #1;
        while (!dmem_req && k < 10) begin
            @(negedge clk); #1; k++;
        end
        check_eq("mid_mem_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dmem", 32'(dmem_req), 32'd0);
        check_eq("async_rst_outs", 32'(all_outs()), 32'd0);
        check_eq("async_rst_ir",   ir, NOP_INSTR);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_idle", 32'(imem_req), 32'd0);
        @(negedge clk); #1;
        check_eq("post_rst_fetch", 32'(imem_req), 32'd1);

`ifdef MULTICYCLE_CTRL_TRAP_ILLEGAL_EN
        // Illegal opcode traps into HALT.
        imem_ready = 1'b1; imem_rdata = 32'h0000007F;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk); #1;
        check_eq("trap_illegal", 32'({illegal, halted}), 32'b11);
        check_eq("trap_quiet", 32'({imem_req, dmem_req, pc_we, reg_we}), 32'd0);
        do_reset();
        check_eq("trap_cleared", 32'({illegal, halted}), 32'd0);
`endif

        // Fetch timeout: imem_ready never arrives.
        imem_ready = 1'b0;
        k = 0;
        while (imem_req && k < 40) begin
            k++;
            @(negedge clk); #1;
        end
        check_eq("timeout_cycles", 32'(k), 32'(WAIT_LIMIT + 1));
        check_eq("timeout_flags", 32'({bus_err, halted}), 32'b11);
        check_eq("timeout_quiet", 32'({imem_req, dmem_req, dmem_we, pc_we, reg_we}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
        end
        check_eq("halt_sticky", 32'({bus_err, halted, imem_req}), 32'b110);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("halt_rst_clear", 32'(all_outs()), 32'd0);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        run_instr(32'h00500093, K_I, 1, 0, 1'b0, "after_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
